// File: rtl/race_game_ctrl.sv
// -----------------------------------------------------------------------------
// race_game_ctrl
//   Two-player "race to TARGET" turn controller. Players alternate adding 1..3
//   to a shared running total; the player whose move brings the total to
//   TARGET or above wins. The total saturates at TARGET.
//
// Optional feature (compile-time macro TURN_TIMEOUT_EN):
//   When defined, a turn with no valid move for TIMEOUT_CYC cycles is
//   forfeited and the other player moves. When undefined, a turn waits
//   indefinitely and TIMEOUT_CYC only takes part in the parameter check.
//
// Parameters
//   TARGET       winning total, 4 .. 2**TOTAL_W-1
//   TOTAL_W      width of the running total
//   TIMEOUT_CYC  idle cycles before a turn is forfeited
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst        synchronous active-high reset
//   i_go1        player 1 move button (level; acted on at its rising edge)
//   i_step1      player 1 move size, sampled on the go1 rising-edge cycle
//   i_go2        player 2 move button (level)
//   i_step2      player 2 move size
//   i_new_game   single-cycle strobe, restart the game
//   o_ill        0 = player 1 to move, 1 = player 2 to move
//   o_who        00 playing, 01 player 1 won, 10 player 2 won
//   o_total      running total
// -----------------------------------------------------------------------------
module race_game_ctrl #(
   parameter int TARGET      = 21,
   parameter int TOTAL_W     = 5,
   parameter int TIMEOUT_CYC = 50_000_000
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_go1,
   input  logic [1:0]         i_step1,
   input  logic               i_go2,
   input  logic [1:0]         i_step2,
   input  logic               i_new_game,
   output logic               o_ill,
   output logic [1:0]         o_who,
   output logic [TOTAL_W-1:0] o_total
);

   // Reject configurations the saturation logic cannot represent.
   if (TARGET < 4 || TARGET > (2**TOTAL_W) - 1 || TIMEOUT_CYC < 2) begin : g_bad_param
      $error("race_game_ctrl: illegal TARGET/TOTAL_W/TIMEOUT_CYC combination");
   end

   localparam logic [TOTAL_W:0]   TARGET_X = (TOTAL_W+1)'(TARGET);
   localparam logic [TOTAL_W-1:0] TARGET_T = TOTAL_W'(TARGET);

   typedef enum logic {
      S_PLAY = 1'b0,
      S_WIN  = 1'b1
   } state_t;

   state_t             r_state;
   logic               r_ill;
   logic [1:0]         r_who;
   logic [TOTAL_W-1:0] r_total;
   logic               r_go1_q;
   logic               r_go2_q;

   logic               w_rise1;
   logic               w_rise2;
   logic               w_rise_cur;
   logic [1:0]         w_step;
   logic               w_move;
   logic [TOTAL_W:0]   w_sum;
   logic               w_reach;

   assign w_rise1    = i_go1 & ~r_go1_q;
   assign w_rise2    = i_go2 & ~r_go2_q;
   // Only the player whose turn it is can move; the other button is ignored.
   assign w_rise_cur = r_ill ? w_rise2 : w_rise1;
   assign w_step     = r_ill ? i_step2 : i_step1;
   assign w_move     = w_rise_cur & (w_step != 2'd0);
   // One extra bit so the sum can never wrap before the TARGET compare.
   assign w_sum      = {1'b0, r_total} + {{(TOTAL_W-1){1'b0}}, w_step};
   assign w_reach    = (w_sum >= TARGET_X);

`ifdef TURN_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
   logic [TMR_W-1:0] r_timer;
`endif

   always_ff @(posedge i_clk) begin
      // Edge registers follow the buttons even during reset, so a button that
      // is already held when reset releases does not register as a new press.
      r_go1_q <= i_go1;
      r_go2_q <= i_go2;

      if (i_rst) begin
         r_state <= S_PLAY;
         r_ill   <= 1'b0;
         r_who   <= 2'b00;
         r_total <= '0;
`ifdef TURN_TIMEOUT_EN
         r_timer <= '0;
`endif
      end else if (i_new_game) begin
         // Restart wins over any same-cycle move. After a win the non-winner
         // opens; since ill still holds the winner, that is simply ~ill.
         r_state <= S_PLAY;
         r_who   <= 2'b00;
         r_total <= '0;
         r_ill   <= (r_state == S_WIN) ? ~r_ill : 1'b0;
`ifdef TURN_TIMEOUT_EN
         r_timer <= '0;
`endif
      end else begin
         case (r_state)
            S_PLAY: begin
               if (w_move) begin
                  if (w_reach) begin
                     r_total <= TARGET_T;
                     r_who   <= r_ill ? 2'b10 : 2'b01;
                     r_state <= S_WIN;
                  end else begin
                     r_total <= w_sum[TOTAL_W-1:0];
                     r_ill   <= ~r_ill;
                  end
`ifdef TURN_TIMEOUT_EN
                  r_timer <= '0;
               end else if (r_timer == TMR_LAST) begin
                  // Idle too long: hand the turn over, total untouched.
                  r_ill   <= ~r_ill;
                  r_timer <= '0;
               end else begin
                  r_timer <= r_timer + TMR_W'(1);
`endif
               end
            end
            S_WIN: begin
`ifdef TURN_TIMEOUT_EN
               r_timer <= '0;
`endif
            end
            default: r_state <= S_PLAY;
         endcase
      end
   end

   assign o_ill   = r_ill;
   assign o_who   = r_who;
   assign o_total = r_total;

endmodule

// File: tb/tb_race_game_ctrl.sv
module tb_race_game_ctrl;

   localparam int TARGET  = 21;
   localparam int TOTAL_W = 5;
   localparam int TCYC    = 8;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               go1 = 1'b0;
   logic [1:0]         s1  = 2'd0;
   logic               go2 = 1'b0;
   logic [1:0]         s2  = 2'd0;
   logic               ng  = 1'b0;
   logic               ill;
   logic [1:0]         who;
   logic [TOTAL_W-1:0] total;

   int errors = 0;
   int checks = 0;

   // Reference model state: plain integers, players numbered 0/1,
   // winner 0 = none, 1 = player 1, 2 = player 2.
   int m_total = 0;
   int m_turn  = 0;
   int m_win   = 0;
   int m_p1    = 0;
   int m_p2    = 0;
   int m_idle  = 0;

   always #5 clk = ~clk;

   race_game_ctrl #(
      .TARGET     (TARGET),
      .TOTAL_W    (TOTAL_W),
      .TIMEOUT_CYC(TCYC)
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_go1     (go1),
      .i_step1   (s1),
      .i_go2     (go2),
      .i_step2   (s2),
      .i_new_game(ng),
      .o_ill     (ill),
      .o_who     (who),
      .o_total   (total)
   );

   // Game rules applied to the inputs seen at one clock edge.
   task automatic model_edge();
      int st;
      bit pressed;
      if (rst) begin
         m_total = 0; m_turn = 0; m_win = 0; m_idle = 0;
      end else if (ng) begin
         m_turn  = (m_win == 1) ? 1 : 0;
         m_total = 0; m_win = 0; m_idle = 0;
      end else if (m_win == 0) begin
         pressed = (m_turn == 0) ? (go1 && m_p1 == 0) : (go2 && m_p2 == 0);
         st      = (m_turn == 0) ? int'(s1) : int'(s2);
         if (pressed && st != 0) begin
            m_idle = 0;
            if (m_total + st >= TARGET) begin
               m_total = TARGET;
               m_win   = m_turn + 1;
            end else begin
               m_total = m_total + st;
               m_turn  = 1 - m_turn;
            end
         end else begin
`ifdef TURN_TIMEOUT_EN
            m_idle = m_idle + 1;
            if (m_idle == TCYC) begin
               m_turn = 1 - m_turn;
               m_idle = 0;
            end
`endif
         end
      end
      m_p1 = go1 ? 1 : 0;
      m_p2 = go2 ? 1 : 0;
   endtask

   task automatic cyc(input logic g1, input logic [1:0] a1,
                      input logic g2, input logic [1:0] a2, input logic n);
      go1 = g1; s1 = a1; go2 = g2; s2 = a2; ng = n;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic mv(input int player, input logic [1:0] st);
      if (player == 1) cyc(1'b1, st, 1'b0, 2'd0, 1'b0);
      else             cyc(1'b0, 2'd0, 1'b1, st, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
      cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (total !== 5'd0 || ill !== 1'b0 || who !== 2'b00) begin
         errors++;
         $display("FAIL reset_state: total=%0d ill=%0b who=%b, expected 0/0/00", total, ill, who);
      end
      // Button held across reset release must not count as a move.
      rst = 1'b1;
      cyc(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
      rst = 1'b0;
      cyc(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
      cyc(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
      checks++;
      if (total !== 5'd0 || ill !== 1'b0) begin
         errors++;
         $display("FAIL held_thru_reset: total=%0d ill=%0b, expected 0/0", total, ill);
      end
      cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
   endtask

   task automatic test_alternate();
      do_reset();
      for (int k = 0; k < 8; k++) begin
         if (k % 2 == 0) mv(1, 2'd3);
         else            mv(2, 2'd2);
         checks++;
         if (total !== 5'(m_total) || ill !== m_turn[0] || who !== m_win[1:0]) begin
            errors++;
            $display("FAIL alternate_move%0d: total=%0d ill=%0b who=%b, expected %0d/%0b/%b",
                     k, total, ill, who, m_total, m_turn[0], m_win[1:0]);
         end
      end
      checks++;
      if (total !== 5'd20 || ill !== 1'b0) begin
         errors++;
         $display("FAIL alternate_total20: total=%0d ill=%0b, expected 20/0", total, ill);
      end
      mv(1, 2'd1);
      checks++;
      if (total !== 5'd21 || who !== 2'b01 || ill !== 1'b0) begin
         errors++;
         $display("FAIL p1_win: total=%0d who=%b ill=%0b, expected 21/01/0", total, who, ill);
      end
      cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
      mv(1, 2'd3);
      cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
      mv(2, 2'd3);
      cyc(1'b1, 2'd2, 1'b1, 2'd2, 1'b0);
      checks++;
      if (total !== 5'd21 || who !== 2'b01 || ill !== 1'b0) begin
         errors++;
         $display("FAIL win_frozen: total=%0d who=%b ill=%0b, expected 21/01/0", total, who, ill);
      end
   endtask

   task automatic build_19_p2();
      do_reset();
      mv(1, 2'd3); mv(2, 2'd3); mv(1, 2'd3); mv(2, 2'd3);
      mv(1, 2'd3); mv(2, 2'd1); mv(1, 2'd3);
      cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
   endtask

   task automatic test_saturate();
      build_19_p2();
      checks++;
      if (total !== 5'd19 || ill !== 1'b1) begin
         errors++;
         $display("FAIL setup_19: total=%0d ill=%0b, expected 19/1", total, ill);
      end
      mv(2, 2'd3);
      checks++;
      if (total !== 5'd21 || who !== 2'b10 || ill !== 1'b1) begin
         errors++;
         $display("FAIL p2_saturate: total=%0d who=%b ill=%0b, expected 21/10/1", total, who, ill);
      end
   endtask

   task automatic test_ignore();
      do_reset();
      mv(2, 2'd3);
      cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
      checks++;
      if (total !== 5'd0 || ill !== 1'b0) begin
         errors++;
         $display("FAIL wrong_player: total=%0d ill=%0b, expected 0/0", total, ill);
      end
      mv(1, 2'd0);
      cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
      checks++;
      if (total !== 5'd0 || ill !== 1'b0) begin
         errors++;
         $display("FAIL step_zero: total=%0d ill=%0b, expected 0/0", total, ill);
      end
      for (int k = 0; k < 10; k++) cyc(1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
      cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
      checks++;
      if (total !== 5'd1 || ill !== 1'b1) begin
         errors++;
         $display("FAIL held_button: total=%0d ill=%0b, expected 1/1", total, ill);
      end
      // Simultaneous presses: only player 2 (current) counts.
      cyc(1'b1, 2'd3, 1'b1, 2'd2, 1'b0);
      checks++;
      if (total !== 5'd3 || ill !== 1'b0) begin
         errors++;
         $display("FAIL simultaneous: total=%0d ill=%0b, expected 3/0", total, ill);
      end
      cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
   endtask

   task automatic test_new_game();
      do_reset();
      mv(1, 2'd3); mv(2, 2'd2); mv(1, 2'd3); mv(2, 2'd2);
      cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
      cyc(1'b1, 2'd3, 1'b0, 2'd0, 1'b1);
      checks++;
      if (total !== 5'd0 || who !== 2'b00 || ill !== 1'b0) begin
         errors++;
         $display("FAIL ng_vs_move: total=%0d who=%b ill=%0b, expected 0/00/0", total, who, ill);
      end
      cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
      build_19_p2();
      mv(2, 2'd3);
      cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
      checks++;
      if (total !== 5'd0 || who !== 2'b00 || ill !== 1'b0) begin
         errors++;
         $display("FAIL ng_after_p2win: total=%0d who=%b ill=%0b, expected 0/00/0", total, who, ill);
      end
      // Player 1 wins with a single 3-step from 18 -> 21; player 2 opens next.
      do_reset();
      mv(1, 2'd3); mv(2, 2'd3); mv(1, 2'd3); mv(2, 2'd3);
      mv(1, 2'd3); mv(2, 2'd3); mv(1, 2'd3); mv(2, 2'd3);
      cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
      mv(1, 2'd3);
      cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
      checks++;
      if (total !== 5'd0 || who !== 2'b00 || ill !== 1'b1) begin
         errors++;
         $display("FAIL ng_after_p1win: total=%0d who=%b ill=%0b, expected 0/00/1", total, who, ill);
      end
   endtask

   task automatic test_timeout();
      do_reset();
`ifdef TURN_TIMEOUT_EN
      for (int k = 0; k < TCYC - 1; k++) cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
      checks++;
      if (ill !== 1'b0) begin
         errors++;
         $display("FAIL timeout_early: ill=%0b, expected 0", ill);
      end
      cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
      checks++;
      if (ill !== 1'b1 || total !== 5'd0) begin
         errors++;
         $display("FAIL timeout_forfeit: ill=%0b total=%0d, expected 1/0", ill, total);
      end
      for (int k = 0; k < TCYC - 1; k++) cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
      mv(2, 2'd2);
      checks++;
      if (ill !== 1'b0 || total !== 5'd2) begin
         errors++;
         $display("FAIL move_in_forfeit_cycle: ill=%0b total=%0d, expected 0/2", ill, total);
      end
`else
      mv(1, 2'd2);
      for (int k = 0; k < 100; k++) cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
      checks++;
      if (ill !== 1'b1 || total !== 5'd2 || who !== 2'b00) begin
         errors++;
         $display("FAIL no_timeout: ill=%0b total=%0d who=%b, expected 1/2/00", ill, total, who);
      end
`endif
   endtask

   task automatic test_mid_reset();
      do_reset();
      mv(1, 2'd3); mv(2, 2'd3); mv(1, 2'd3); mv(2, 2'd2); mv(1, 2'd1);
      cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
      checks++;
      if (total !== 5'd12 || ill !== 1'b1) begin
         errors++;
         $display("FAIL setup_12: total=%0d ill=%0b, expected 12/1", total, ill);
      end
      rst = 1'b1;
      cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
      rst = 1'b0;
      checks++;
      if (total !== 5'd0 || ill !== 1'b0 || who !== 2'b00) begin
         errors++;
         $display("FAIL mid_reset: total=%0d ill=%0b who=%b, expected 0/0/00", total, ill, who);
      end
   endtask

   task automatic test_random();
      logic g1, g2, n;
      logic [1:0] a1, a2;
      do_reset();
      for (int k = 0; k < 1500; k++) begin
         rst = ($urandom_range(0, 120) == 0);
         n   = ($urandom_range(0, 25) == 0);
         g1  = $urandom_range(0, 1) == 1;
         g2  = $urandom_range(0, 1) == 1;
         a1  = 2'($urandom_range(0, 3));
         a2  = 2'($urandom_range(0, 3));
         cyc(g1, a1, g2, a2, n);
         checks++;
         if (total !== 5'(m_total) || ill !== m_turn[0] || who !== m_win[1:0]) begin
            errors++;
            $display("FAIL random_cycle%0d: total=%0d ill=%0b who=%b, expected %0d/%0b/%b",
                     k, total, ill, who, m_total, m_turn[0], m_win[1:0]);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_alternate();
      test_saturate();
      test_ignore();
      test_new_game();
      test_timeout();
      test_mid_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
